// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operation dispatcher: FSM states, default
// field widths and the function-group indices carried in ALU_FUN's select field.
package alu_pkg;

  localparam int FUN_W_DEF = 4;
  localparam int SEL_W_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_t;

  localparam logic [1:0] GRP_ARITH = 2'd0;
  localparam logic [1:0] GRP_LOGIC = 2'd1;
  localparam logic [1:0] GRP_CMP   = 2'd2;
  localparam logic [1:0] GRP_SHIFT = 2'd3;

endpackage

// File: rtl/alu_lat_counter.sv
// Loadable down-counter for execution-unit latency; tc is registered together
// with the count so it is valid in the first WAIT cycle.
module alu_lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt_r;
  logic         tc_r;

  // Count register and its terminal-count flag; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      tc_r  <= 1'b0;
    end else if (load) begin
      cnt_r <= load_val;
      tc_r  <= (load_val == W'(1));
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - W'(1);
      tc_r  <= (cnt_r == W'(2));
    end else begin
      cnt_r <= cnt_r;
      tc_r  <= tc_r;
    end
  end

  assign tc = tc_r;

endmodule

// File: rtl/alu_op_dispatcher.sv
// Sequential ALU dispatcher: accepts one op, pulses a one-hot unit enable and
// raises OUT_VALID once the selected unit's latency has elapsed.
module alu_op_dispatcher
  import alu_pkg::*;
#(
  parameter int                            FUN_W     = FUN_W_DEF,
  parameter int                            SEL_W     = SEL_W_DEF,
  parameter int                            LAT_W     = 3,
  parameter logic [(2**SEL_W)*LAT_W-1:0]   UNIT_LAT  = {3'd1, 3'd1, 3'd1, 3'd2},
  parameter logic [(2**SEL_W)-1:0]         UNIT_MASK = 4'b1111
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [FUN_W-1:0]         ALU_FUN,
  input  logic                     EN,
  output logic                     BUSY,
  output logic [(2**SEL_W)-1:0]    UNIT_EN,
  output logic [SEL_W-1:0]         UNIT_SEL,
  output logic [FUN_W-SEL_W-1:0]   SUB_FUN,
  output logic                     OUT_VALID,
  output logic                     ILLEGAL
);

  localparam int NUM_UNITS = 2**SEL_W;
  localparam int SUB_W     = FUN_W - SEL_W;

  // A zero latency entry still needs one cycle for the unit to respond.
  function automatic logic [LAT_W-1:0] unit_lat_f(input logic [SEL_W-1:0] sel);
    logic [LAT_W-1:0] lat;
    lat = UNIT_LAT[int'(sel)*LAT_W +: LAT_W];
    return (lat == '0) ? LAT_W'(1) : lat;
  endfunction

  state_t               state_r;
  logic                 busy_r;
  logic [NUM_UNITS-1:0] unit_en_r;
  logic [SEL_W-1:0]     unit_sel_r;
  logic [SUB_W-1:0]     sub_fun_r;
  logic                 out_valid_r;
  logic                 illegal_r;

  logic [SEL_W-1:0]     sel_in_s;
  logic [SUB_W-1:0]     sub_in_s;
  logic [LAT_W-1:0]     lat_s;
  logic [LAT_W-1:0]     ld_val_s;
  logic                 ld_s;
  logic                 dec_s;
  logic                 tc_s;

  // Field split of the request and counter control derived from the FSM state.
  always_comb begin
    sel_in_s = ALU_FUN[FUN_W-1 -: SEL_W];
    sub_in_s = ALU_FUN[SUB_W-1:0];
    lat_s    = unit_lat_f(unit_sel_r);
    ld_val_s = lat_s - LAT_W'(1);
    ld_s     = (state_r == ST_ISSUE);
    dec_s    = (state_r == ST_WAIT);
  end

  alu_lat_counter #(.W(LAT_W)) u_lat_counter (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (ld_s),
    .load_val (ld_val_s),
    .dec      (dec_s),
    .tc       (tc_s)
  );

  // Dispatch FSM; every output is a register updated alongside the state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      unit_en_r   <= '0;
      unit_sel_r  <= '0;
      sub_fun_r   <= '0;
      out_valid_r <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      unit_en_r   <= '0;
      out_valid_r <= 1'b0;
      illegal_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (EN) begin
            if (UNIT_MASK[sel_in_s]) begin
              state_r    <= ST_ISSUE;
              busy_r     <= 1'b1;
              unit_en_r  <= NUM_UNITS'(1'b1) << sel_in_s;
              unit_sel_r <= sel_in_s;
              sub_fun_r  <= sub_in_s;
            end else begin
              illegal_r  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (lat_s == LAT_W'(1)) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
          end else begin
            state_r     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tc_s) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY      = busy_r;
  assign UNIT_EN   = unit_en_r;
  assign UNIT_SEL  = unit_sel_r;
  assign SUB_FUN   = sub_fun_r;
  assign OUT_VALID = out_valid_r;
  assign ILLEGAL   = illegal_r;

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Bench for alu_op_dispatcher: two instances (shift unit absent / long latencies),
// table-driven ops plus hand sequences, with a cycle-stamped event scoreboard.
module tb_alu_op_dispatcher;
  import alu_pkg::*;

  typedef struct {
    int         d;
    int         cyc;
    logic [3:0] ue;
    logic [1:0] sel;
    logic [1:0] sub;
  } ev_t;

  typedef struct {
    int         d;
    logic [3:0] f;
    int         lat;
    bit         legal;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] fun       [2];
  logic       en        [2];
  logic       busy      [2];
  logic [3:0] unit_en   [2];
  logic [1:0] unit_sel  [2];
  logic [1:0] sub_fun   [2];
  logic       out_valid [2];
  logic       illegal   [2];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  ev_t  ue_q[$];
  ev_t  ov_q[$];
  ev_t  il_q[$];
  logic [1:0] last_sel [2];
  logic [1:0] last_sub [2];
  vec_t vecs [8];

  always #5 clk = ~clk;

  // dut_a: default latencies, shift unit absent.
  alu_op_dispatcher #(.UNIT_MASK(4'b0111)) dut_a (
    .CLK(clk), .RST(rst_n), .ALU_FUN(fun[0]), .EN(en[0]), .BUSY(busy[0]),
    .UNIT_EN(unit_en[0]), .UNIT_SEL(unit_sel[0]), .SUB_FUN(sub_fun[0]),
    .OUT_VALID(out_valid[0]), .ILLEGAL(illegal[0])
  );

  // dut_b: latencies unit0=2, unit1=0 (acts as 1), unit2=3, unit3=7.
  alu_op_dispatcher #(.UNIT_LAT({3'd7, 3'd3, 3'd0, 3'd2}), .UNIT_MASK(4'b1111)) dut_b (
    .CLK(clk), .RST(rst_n), .ALU_FUN(fun[1]), .EN(en[1]), .BUSY(busy[1]),
    .UNIT_EN(unit_en[1]), .UNIT_SEL(unit_sel[1]), .SUB_FUN(sub_fun[1]),
    .OUT_VALID(out_valid[1]), .ILLEGAL(illegal[1])
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic miss(input string name, input ev_t e);
    checks++;
    failures++;
    $display("FAIL %s_missing dut=%0d: got no pulse, expected one at cycle %0d", name, e.d, e.cyc);
  endtask

  task automatic extra(input string name, input int d);
    checks++;
    failures++;
    $display("FAIL %s_unexpected dut=%0d: got a pulse at cycle %0d, expected none", name, d, cyc);
  endtask

  task automatic cmp_ev(input string name, input int d, input ev_t e);
    check({name, "_unit_en"}, int'(unit_en[d]), int'(e.ue));
    check({name, "_unit_sel"}, int'(unit_sel[d]), int'(e.sel));
    check({name, "_sub_fun"}, int'(sub_fun[d]), int'(e.sub));
  endtask

  task automatic mon();
    while (ue_q.size() > 0 && ue_q[0].cyc < cyc) miss("unit_en", ue_q.pop_front());
    while (ov_q.size() > 0 && ov_q[0].cyc < cyc) miss("out_valid", ov_q.pop_front());
    while (il_q.size() > 0 && il_q[0].cyc < cyc) miss("illegal", il_q.pop_front());
    for (int d = 0; d < 2; d++) begin
      if (unit_en[d] != 4'b0000) begin
        if (ue_q.size() > 0 && ue_q[0].d == d && ue_q[0].cyc == cyc) cmp_ev("unit_en", d, ue_q.pop_front());
        else extra("unit_en", d);
      end
      if (out_valid[d]) begin
        if (ov_q.size() > 0 && ov_q[0].d == d && ov_q[0].cyc == cyc) cmp_ev("out_valid", d, ov_q.pop_front());
        else extra("out_valid", d);
      end
      if (illegal[d]) begin
        if (il_q.size() > 0 && il_q[0].d == d && il_q[0].cyc == cyc) cmp_ev("illegal", d, il_q.pop_front());
        else extra("illegal", d);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    mon();
  endtask

  task automatic expect_op(input int d, input logic [3:0] f, input int acc, input int lat);
    ue_q.push_back('{d, acc + 1, 4'b0001 << f[3:2], f[3:2], f[1:0]});
    ov_q.push_back('{d, acc + lat + 1, 4'b0000, f[3:2], f[1:0]});
    last_sel[d] = f[3:2];
    last_sub[d] = f[1:0];
  endtask

  task automatic check_zero(input int d);
    check("rst_busy", int'(busy[d]), 0);
    check("rst_unit_en", int'(unit_en[d]), 0);
    check("rst_unit_sel", int'(unit_sel[d]), 0);
    check("rst_sub_fun", int'(sub_fun[d]), 0);
    check("rst_out_valid", int'(out_valid[d]), 0);
    check("rst_illegal", int'(illegal[d]), 0);
  endtask

  // One EN pulse, then watch BUSY until the op should have completed.
  task automatic run_op(input int d, input logic [3:0] f, input int lat, input bit legal);
    int acc;
    acc = cyc;
    en[d]  = 1'b1;
    fun[d] = f;
    if (legal) expect_op(d, f, acc, lat);
    else il_q.push_back('{d, acc + 1, 4'b0000, last_sel[d], last_sub[d]});
    tick();
    en[d]  = 1'b0;
    fun[d] = ~f;
    for (int i = 1; i <= lat + 1; i++) begin
      check("busy", int'(busy[d]), (legal && i <= lat) ? 1 : 0);
      if (i == lat + 1) begin
        check("held_unit_sel", int'(unit_sel[d]), int'(last_sel[d]));
        check("held_sub_fun", int'(sub_fun[d]), int'(last_sub[d]));
      end
      tick();
    end
  endtask

  initial begin
    int acc;
    vecs[0] = '{0, {GRP_LOGIC, 2'b11}, 1, 1'b1};
    vecs[1] = '{0, {GRP_CMP, 2'b01},   1, 1'b1};
    vecs[2] = '{0, {GRP_SHIFT, 2'b01}, 0, 1'b0};
    vecs[3] = '{0, {GRP_ARITH, 2'b00}, 2, 1'b1};
    vecs[4] = '{1, {GRP_ARITH, 2'b10}, 2, 1'b1};
    vecs[5] = '{1, {GRP_LOGIC, 2'b01}, 1, 1'b1};
    vecs[6] = '{1, {GRP_CMP, 2'b11},   3, 1'b1};
    vecs[7] = '{1, {GRP_SHIFT, 2'b10}, 7, 1'b1};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en[d]       = 1'b1;
      fun[d]      = {GRP_LOGIC, 2'b11};
      last_sel[d] = 2'b00;
      last_sub[d] = 2'b00;
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) check_zero(d);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) en[d] = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) check("idle_busy", int'(busy[d]), 0);

    for (int v = 0; v < 8; v++) run_op(vecs[v].d, vecs[v].f, vecs[v].lat, vecs[v].legal);

    // Arith op (L=2) with a request to the absent shift unit while busy.
    acc = cyc;
    en[0]  = 1'b1;
    fun[0] = {GRP_ARITH, 2'b01};
    expect_op(0, fun[0], acc, 2);
    tick();
    en[0] = 1'b0;
    check("arith_busy_c1", int'(busy[0]), 1);
    tick();
    check("arith_busy_c2", int'(busy[0]), 1);
    en[0]  = 1'b1;
    fun[0] = {GRP_SHIFT, 2'b00};
    tick();
    en[0] = 1'b0;
    check("arith_busy_c3", int'(busy[0]), 0);
    repeat (2) tick();

    // EN held high: one compare op every two cycles.
    acc = cyc;
    en[0]  = 1'b1;
    fun[0] = {GRP_CMP, 2'b00};
    for (int k = 0; k < 3; k++) expect_op(0, fun[0], acc + 2 * k, 1);
    repeat (2) tick();
    check("b2b_busy_ov_cycle", int'(busy[0]), 0);
    repeat (3) tick();
    en[0] = 1'b0;
    repeat (3) tick();

    // Reset during WAIT of an arith op: no OUT_VALID may follow.
    acc = cyc;
    en[0]  = 1'b1;
    fun[0] = {GRP_ARITH, 2'b11};
    ue_q.push_back('{0, acc + 1, 4'b0001, GRP_ARITH, 2'b11});
    tick();
    en[0] = 1'b0;
    tick();
    check("wait_busy", int'(busy[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) check_zero(d);
    tick();
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      last_sel[d] = 2'b00;
      last_sub[d] = 2'b00;
    end
    repeat (4) tick();
    check("post_rst_busy", int'(busy[0]), 0);
    run_op(0, {GRP_ARITH, 2'b10}, 2, 1'b1);
    run_op(1, {GRP_CMP, 2'b01}, 3, 1'b1);

    repeat (2) tick();
    while (ue_q.size() > 0) miss("unit_en", ue_q.pop_front());
    while (ov_q.size() > 0) miss("out_valid", ov_q.pop_front());
    while (il_q.size() > 0) miss("illegal", il_q.pop_front());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_dispatcher.md
Name: alu_op_dispatcher

Overview:
- Parametrised, sequential successor to the combinational ALU function-group decoder.
- Accepts one ALU operation at a time, decodes the group-select field of ALU_FUN into a one-hot, one-cycle unit enable, and forwards the sub-function bits.
- Tracks a per-unit latency and pulses OUT_VALID when the selected unit's result is due.
- Sits between the system controller and the ALU execution units. Replaces the plain decoder when units are multi-cycle or optional.

Parameters:
- FUN_W, 4, width of ALU_FUN.
- SEL_W, 2, width of the group-select field, which occupies ALU_FUN[FUN_W-1 -: SEL_W]; NUM_UNITS = 2**SEL_W.
- LAT_W, 3, width of each per-unit latency entry.
- UNIT_LAT, {3'd1,3'd1,3'd1,3'd2}, packed NUM_UNITS*LAT_W latencies; entry i = unit i (unit 0 in the LSBs); value 0 is treated as 1.
- UNIT_MASK, 4'b1111, bit i = 1 means unit i is present.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- ALU_FUN  in  FUN_W  operation code; select = upper SEL_W bits, sub-function = lower FUN_W-SEL_W bits.
- EN  in  1  request valid; sampled only when BUSY=0.
- BUSY  out  1  operation in flight; requests are ignored while high.
- UNIT_EN  out  NUM_UNITS  one-hot unit enable, high for exactly one cycle per accepted op.
- UNIT_SEL  out  SEL_W  registered select of the current or last op.
- SUB_FUN  out  FUN_W-SEL_W  registered sub-function, held stable from ISSUE until the next accept.
- OUT_VALID  out  1  one-cycle pulse: the selected unit's result is valid.
- ILLEGAL  out  1  one-cycle pulse: the request targeted an absent unit.

Behaviour:
- Reset (RST=0, async): state=IDLE; BUSY, UNIT_EN, UNIT_SEL, SUB_FUN, OUT_VALID, ILLEGAL, and the latency counter all 0. Reset mid-operation aborts the op with no OUT_VALID.
- All outputs are registered; no combinational path from input to output.
- States: IDLE, ISSUE, WAIT. BUSY = (state != IDLE).
- IDLE, EN=1, UNIT_MASK[sel]=1: latch sel and sub-function; go to ISSUE.
- IDLE, EN=1, UNIT_MASK[sel]=0: stay in IDLE; ILLEGAL=1 next cycle; no UNIT_EN or OUT_VALID; UNIT_SEL and SUB_FUN unchanged.
- IDLE, EN=0: no change.
- ISSUE (cycle n):
  - UNIT_EN[sel]=1, all other bits 0; counter loaded with L-1, where L = max(UNIT_LAT[sel],1).
  - If L=1: go to IDLE with OUT_VALID=1 in cycle n+1.
  - Else: go to WAIT.
- WAIT: counter decrements each cycle. When the counter reaches 1, go to IDLE with OUT_VALID=1 in the next cycle.
- Timing rule: OUT_VALID is asserted exactly L cycles after the UNIT_EN cycle, i.e. EN-accept cycle + L + 1.
- The OUT_VALID cycle is an IDLE cycle (BUSY=0), so EN in that cycle is accepted; back-to-back throughput is one op per L+1 cycles.
- EN while BUSY=1: ignored. There is no queueing and no error flag.
- ALU_FUN changes during ISSUE or WAIT have no effect.
- Counter width is LAT_W; the maximum latency 2**LAT_W-1 must not wrap.

Decomposition:
- Shared package alu_pkg: state encoding (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10), default FUN_W, SEL_W, and the group indices ARITH=0, LOGIC=1, CMP=2, SHIFT=3.
- One natural sub-module, alu_lat_counter: loadable down-counter that flags terminal count, instantiated once.
- The one-hot decode stays inline.

Test Plan:
- Reset: hold RST=0 with EN=1 → all outputs 0; release RST → BUSY=0 and nothing fires until EN is sampled.
- Default params, ALU_FUN=4'b0111, EN pulse at cycle 0 → UNIT_EN=4'b0010 and SUB_FUN=2'b11 at cycle 1; OUT_VALID at cycle 2; BUSY high in cycle 1 only.
- ALU_FUN=4'b0001 (arith, L=2), EN at cycle 0 → UNIT_EN=4'b0001 at cycle 1; OUT_VALID at cycle 3; EN=1 with ALU_FUN=4'b1100 at cycle 2 is ignored.
- Back-to-back: EN held at 1 with ALU_FUN=4'b1000 → UNIT_EN=4'b0100 at cycles 1, 3, 5; OUT_VALID at cycles 2, 4, 6.
- UNIT_MASK=4'b0111, ALU_FUN=4'b1101, EN at cycle 0 → ILLEGAL at cycle 1; UNIT_EN=0, BUSY=0, OUT_VALID never asserted.
- RST pulled low during WAIT of an arith op → outputs clear immediately; no OUT_VALID after release; next op runs normally.
